// File: rtl/sort_pkg.sv
// Shared types for the sorted-triple serializer.
//   SORT_W      default element width
//   elem_t      one element
//   triple_t    one sorted triple {a, b, c}, a in the most significant slot
//   elem_idx_e  position of the element currently presented on the output
//   next_idx    E0 -> E1 -> E2 -> E0 sequencing of elem_idx_e
package sort_pkg;

  localparam int SORT_W = 8;

  typedef logic [SORT_W-1:0] elem_t;

  typedef struct packed {
    elem_t a;
    elem_t b;
    elem_t c;
  } triple_t;

  typedef enum logic [1:0] {
    E0 = 2'd0,
    E1 = 2'd1,
    E2 = 2'd2
  } elem_idx_e;

  function automatic elem_idx_e next_idx(input elem_idx_e cur);
    case (cur)
      E0:      return E1;
      E1:      return E2;
      default: return E0;
    endcase
  endfunction

endpackage

// File: rtl/triple_fifo.sv
// Triple FIFO: DEPTH entries of WIDTH bits (one packed triple per entry).
// Ports:
//   clk      in   clock, all state on posedge
//   rst      in   asynchronous active-high reset (pointers and count only)
//   push     in   write wr_data at wr_ptr; caller guarantees !full
//   pop      in   retire the head entry; caller guarantees !empty
//   wr_data  in   WIDTH  entry to write
//   rd_data  out  WIDTH  head entry (combinational read)
//   full     out  count == DEPTH
//   empty    out  count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module triple_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  // NOTE: storage has no reset; validity is tracked by count, so clearing the
  // array would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: registers use non-blocking assignments so every update in this
  // block sees the pre-edge values of count and the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;  // idle, or push and pop cancel out
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/sorted_triple_serializer.sv
// Sorted-triple serializer: buffers sorted triples (a <= b <= c) in a small
// FIFO and emits them one element per handshake, smallest first, with out_last
// on the third element.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-high reset
//   in_valid   in   triple on in_a/in_b/in_c is valid
//   in_ready   out  FIFO can accept a triple this cycle
//   in_a/b/c   in   W  smallest / middle / largest element
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data this cycle
//   out_data   out  W  current element
//   out_idx    out  2  position of out_data in its triple (0..2)
//   out_last   out  high on the third element of a triple
//   order_err  out  sticky flag: an unsorted triple was pushed
// Build option: define ORDER_CHECK_EN to build the ordering check; without it
// order_err is tied to 0.
module sorted_triple_serializer
  import sort_pkg::*;
#(
  parameter int W     = SORT_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         order_err
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } entry_t;

  entry_t    wr_entry;
  entry_t    head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  elem_idx_e idx;
  elem_idx_e idx_next;

  // Both handshakes are gated by rst so nothing is offered while reset is held.
  assign in_ready  = !full  && !rst;
  assign out_valid = !empty && !rst;
  assign push      = in_valid && in_ready;
  // The head entry retires only once its last element has been accepted.
  assign pop       = out_valid && out_ready && (idx == E2);

  assign wr_entry = '{a: in_a, b: in_b, c: in_c};

  triple_fifo #(
    .WIDTH (3 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx <= E0;
    else     idx <= idx_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    idx_next = idx;
    out_data = head.a;
    out_last = 1'b0;
    if (out_valid && out_ready) idx_next = next_idx(idx);
    case (idx)
      E1:      out_data = head.b;
      E2: begin
        out_data = head.c;
        out_last = 1'b1;
      end
      default: out_data = head.a;
    endcase
  end

  assign out_idx = idx;

`ifdef ORDER_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      order_err <= 1'b0;
    else if (push && !((in_a <= in_b) && (in_b <= in_c)))
      order_err <= 1'b1;
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_triple_serializer.sv
// Bench for sorted_triple_serializer (W=8, DEPTH=2). Stimulus records the
// expected element stream when a push is accepted; a monitor pops and compares
// on every output handshake.
module tb_sorted_triple_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
  logic       order_err;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef ORDER_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  sorted_triple_serializer #(.W(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one triple until accepted or the budget runs out. waits counts the
  // sampled cycles where in_ready was low before acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input int budget, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    while (!done && waits < budget) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{data: a, idx: 2'd0, last: 1'b0});
        exp_q.push_back('{data: b, idx: 2'd1, last: 1'b0});
        exp_q.push_back('{data: c, idx: 2'd2, last: 1'b1});
        done = 1'b1;
      end else begin
        waits++;
      end
      step();
    end
    in_valid = 1'b0;
    check("push_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
    step();
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_data", {24'd0, out_data}, {24'd0, e.data});
          check("sb_out_idx",  {30'd0, out_idx},  {30'd0, e.idx});
          check("sb_out_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int hi, tot;
    logic [7:0] r0, r1, r2, t;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    repeat (3) step();
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_idx",   {30'd0, out_idx},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_order_err", {31'd0, order_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1. asynchronous reset pulse mid-cycle with in_valid high
    step();
    in_valid = 1'b1; in_a = 8'd11; in_b = 8'd12; in_c = 8'd13;
    #2 rst = 1'b1;
    #1;
    check("async_rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rel_in_ready",  {31'd0, in_ready},  32'd1);
    check("async_rel_out_valid", {31'd0, out_valid}, 32'd0);

    // 2. single triple, consumer always ready
    out_ready = 1'b1;
    send(8'd3, 8'd7, 8'd9, 10, w);
    @(negedge clk);
    check("t2_e0_valid", {31'd0, out_valid}, 32'd1);
    check("t2_e0_data",  {24'd0, out_data},  32'd3);
    check("t2_e0_last",  {31'd0, out_last},  32'd0);
    @(negedge clk);
    check("t2_e1_data",  {24'd0, out_data},  32'd7);
    check("t2_e1_idx",   {30'd0, out_idx},   32'd1);
    @(negedge clk);
    check("t2_e2_data",  {24'd0, out_data},  32'd9);
    check("t2_e2_last",  {31'd0, out_last},  32'd1);
    @(negedge clk);
    check("t2_done_valid", {31'd0, out_valid}, 32'd0);
    step();

    // 3. consumer stalled: fill the FIFO, third triple held off
    out_ready = 1'b0;
    send(8'd1, 8'd2, 8'd3, 10, w);
    send(8'd4, 8'd5, 8'd6, 10, w);
    check("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
    in_a = 8'd7; in_b = 8'd8; in_c = 8'd9; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_hold_data",     {24'd0, out_data}, 32'd1);
      check("t3_hold_idx",      {30'd0, out_idx},  32'd0);
      step();
    end

    // 4. release the consumer: space opens only after the head's E2 pop
    out_ready = 1'b1;
    send(8'd7, 8'd8, 8'd9, 20, w);
    check("t4_waits_before_space", w, 3);
    drain("t4");

    // 5. 30 random sorted triples, continuous traffic
    hi = 0; tot = 0;
    for (int i = 0; i < 30; i++) begin
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      if (r0 > r1) begin t = r0; r0 = r1; r1 = t; end
      if (r1 > r2) begin t = r1; r1 = r2; r2 = t; end
      if (r0 > r1) begin t = r0; r0 = r1; r1 = t; end
      send(r0, r1, r2, 20, w);
      if (i >= 2) begin
        hi  += 1;
        tot += w + 1;
      end
    end
    check("t5_in_ready_duty_x3", hi * 3, tot);
    drain("t5");

    // 6. unsorted triple
    check("t6_order_err_before", {31'd0, order_err}, 32'd0);
    send(8'd9, 8'd2, 8'd5, 10, w);
    check("t6_order_err_set", {31'd0, order_err}, {31'd0, ERR_EXP});
    send(8'd1, 8'd1, 8'd2, 10, w);
    send(8'd4, 8'd5, 8'd6, 10, w);
    drain("t6");
    check("t6_order_err_sticky", {31'd0, order_err}, {31'd0, ERR_EXP});

    // 7. reset while a triple is partially emitted
    out_ready = 1'b0;
    send(8'd10, 8'd20, 8'd30, 10, w);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t7_mid_idx",  {30'd0, out_idx},  32'd1);
    check("t7_mid_data", {24'd0, out_data}, 32'd20);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("t7_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t7_rst_out_idx",   {30'd0, out_idx},   32'd0);
    check("t7_rst_order_err", {31'd0, order_err}, 32'd0);
    check("t7_rst_in_ready",  {31'd0, in_ready},  32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t7_after_out_valid", {31'd0, out_valid}, 32'd0);
    check("t7_after_in_ready",  {31'd0, in_ready},  32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
